wrapper_vr_packet_loopback: RTL

- AHB-Lite slave wrapper that generalises the single-word valid-ready loopback to multi-word packets.
- Host writes PACKETWIDTH-bit packets as 32-bit words into an input window. Completed packets pass over an internal valid-ready channel into a FIFODEPTH-deep packet FIFO.
- Packets are read back word-by-word from an output window.
- Sits at 0x60010000 behind the slave mux. It serves as the template for accelerator wrappers, where the FIFO is later replaced by the accelerator core.

---
 rtl/wrapper_vr_packet_loopback_if.sv | 27 ++
 rtl/wrapper_vr_packet_loopback.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wrapper_vr_packet_loopback_if.sv
// AHB-Lite slave-side bus bundle for the packet loopback wrapper.
//   HSELS, HADDRS, HTRANSS, HSIZES, HWRITES, HREADYS, HWDATAS : master -> slave
//   HREADYOUTS, HRESPS, HRDATAS                              : slave -> master
interface wrapper_vr_packet_loopback_if #(
  parameter int unsigned ADDRWIDTH = 12
);
  logic                 HSELS;
  logic [ADDRWIDTH-1:0] HADDRS;
  logic [1:0]           HTRANSS;
  logic [2:0]           HSIZES;
  logic                 HWRITES;
  logic                 HREADYS;
  logic [31:0]          HWDATAS;
  logic                 HREADYOUTS;
  logic                 HRESPS;
  logic [31:0]          HRDATAS;

  modport master (
    output HSELS, HADDRS, HTRANSS, HSIZES, HWRITES, HREADYS, HWDATAS,
    input  HREADYOUTS, HRESPS, HRDATAS
  );

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HSIZES, HWRITES, HREADYS, HWDATAS,
    output HREADYOUTS, HRESPS, HRDATAS
  );
endinterface

// File: rtl/wrapper_vr_packet_loopback.sv
// AHB-Lite packet loopback: 32-bit writes to the input window assemble PACKETWIDTH-bit
// packets, which cross a valid-ready channel into a FIFODEPTH-deep packet FIFO and are
// read back word by word from the output window.
// Ports:
//   HCLK      clock, rising edge
//   HRESET    synchronous active-high reset
//   bus       AHB-Lite slave bundle (select/address/control/write data in, ready/resp/rdata out)
//   pkt_avail high while at least one output word is readable
// Map: 0x000-0x3FC input window, 0x400-0x7FC output window, 0x800 STATUS (RO),
//      0x804 CTRL (WO, bit0 flush, bit1 clear sticky flags). ADDRWIDTH must be >= 12.
module wrapper_vr_packet_loopback #(
  parameter int unsigned ADDRWIDTH   = 12,
  parameter int unsigned PACKETWIDTH = 512,
  parameter int unsigned FIFODEPTH   = 4
) (
  input  logic                               HCLK,
  input  logic                               HRESET,
  wrapper_vr_packet_loopback_if.slave        bus,
  output logic                               pkt_avail
);
  localparam int unsigned NWORDS = PACKETWIDTH / 32;
  localparam int unsigned WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned PTRW   = $clog2(FIFODEPTH);
  localparam int unsigned CNTW   = PTRW + 1;
  localparam logic [WCW-1:0] LastWord = WCW'(NWORDS - 1);

  typedef enum logic [0:0] {StIdle, StErr} state_e;
  state_e state_q, state_d;

  // Registered address phase
  logic        dp_valid_q, dp_write_q;
  logic [11:0] dp_addr_q;
  logic [2:0]  dp_size_q;

  logic [PACKETWIDTH-1:0] pkt_in_q, pkt_in_d;
  logic [WCW-1:0]         in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic                   in_valid_q, in_valid_d;
  logic                   ovf_q, ovf_d, unf_q, unf_d;
  logic [PACKETWIDTH-1:0] mem_q [FIFODEPTH];
  logic [PTRW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]        count_q, count_d;

  logic accept, is_in, is_out, is_status, is_ctrl;
  logic rd_req, wr_req, wr_err, rd_err, word_wr, word_rd;
  logic push, pop, in_ready, fifo_full, fifo_empty;
  logic ctrl_wr, flush, clr_flags;
  logic hready, hresp;
  logic [PACKETWIDTH-1:0] head;
  logic [31:0] rdata, status;
  logic unused_bits;

  assign unused_bits = bus.HTRANSS[0];
  assign accept      = bus.HSELS & bus.HREADYS & bus.HTRANSS[1];
  assign fifo_full   = (count_q == CNTW'(FIFODEPTH));
  assign fifo_empty  = (count_q == '0);
  assign head        = mem_q[rd_ptr_q];

  // Data-phase decode and the internal valid-ready channel
  always_comb begin
    is_in     = (dp_addr_q[11:10] == 2'b00);
    is_out    = (dp_addr_q[11:10] == 2'b01);
    is_status = (dp_addr_q == 12'h800);
    is_ctrl   = (dp_addr_q == 12'h804);
    rd_req    = dp_valid_q & ~dp_write_q & is_out;
    wr_req    = dp_valid_q & dp_write_q & is_in;
    // A held packet can only be waiting on a full FIFO
    wr_err    = wr_req & ((dp_size_q != 3'b010) | (in_valid_q & fifo_full));
    rd_err    = rd_req & fifo_empty;
    word_wr   = wr_req & ~wr_err;
    word_rd   = rd_req & ~rd_err;
    pop       = word_rd & (out_cnt_q == LastWord);
    // A same-cycle pop frees the slot, so a full FIFO can still take the held packet
    in_ready  = ~fifo_full | pop;
    push      = in_valid_q & in_ready;
    ctrl_wr   = dp_valid_q & dp_write_q & is_ctrl;
    flush     = ctrl_wr & bus.HWDATAS[0];
    clr_flags = ctrl_wr & bus.HWDATAS[1];
  end

  always_comb begin
    pkt_in_d   = pkt_in_q;
    in_cnt_d   = in_cnt_q;
    in_valid_d = in_valid_q & ~push;
    out_cnt_d  = out_cnt_q;
    count_d    = count_q;
    ovf_d      = ovf_q | wr_err;
    unf_d      = unf_q | rd_err;
    if (clr_flags) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (word_wr) begin
      pkt_in_d[32*int'(in_cnt_q) +: 32] = bus.HWDATAS;
      if (in_cnt_q == LastWord) begin
        in_cnt_d   = '0;
        in_valid_d = 1'b1;
      end else begin
        in_cnt_d = in_cnt_q + WCW'(1);
      end
    end
    if (word_rd) begin
      out_cnt_d = (out_cnt_q == LastWord) ? '0 : out_cnt_q + WCW'(1);
    end
    if (push && !pop) count_d = count_q + CNTW'(1);
    else if (pop && !push) count_d = count_q - CNTW'(1);
    if (flush) begin
      pkt_in_d   = '0;
      in_cnt_d   = '0;
      in_valid_d = 1'b0;
      out_cnt_d  = '0;
      count_d    = '0;
    end
  end

  // Error response: first cycle stalls with HRESP, second releases with HRESP
  always_comb begin
    state_d = state_q;
    hready  = 1'b1;
    hresp   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_err || rd_err) begin
          hready  = 1'b0;
          hresp   = 1'b1;
          state_d = StErr;
        end
      end
      StErr: begin
        hresp   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    status = {8'(out_cnt_q), 8'(in_cnt_q), 8'(count_q), 4'b0000,
              unf_q, ovf_q, ~fifo_empty, ~in_valid_q};
    rdata  = '0;
    if (dp_valid_q && !dp_write_q) begin
      if (is_out && !fifo_empty) rdata = head[32*int'(out_cnt_q) +: 32];
      else if (is_status)        rdata = status;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= StIdle;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      dp_size_q  <= '0;
      pkt_in_q   <= '0;
      in_cnt_q   <= '0;
      in_valid_q <= 1'b0;
      out_cnt_q  <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      dp_valid_q <= accept;
      dp_write_q <= bus.HWRITES;
      dp_addr_q  <= bus.HADDRS[11:0];
      dp_size_q  <= bus.HSIZES;
      pkt_in_q   <= pkt_in_d;
      in_cnt_q   <= in_cnt_d;
      in_valid_q <= in_valid_d;
      out_cnt_q  <= out_cnt_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
      end
    end
  end

  // Packet storage needs no reset: only the pointers and count define its contents
  always_ff @(posedge HCLK) begin
    if (push && !flush && !HRESET) mem_q[wr_ptr_q] <= pkt_in_q;
  end

  assign bus.HREADYOUTS = hready | HRESET;
  assign bus.HRESPS     = hresp & ~HRESET;
  assign bus.HRDATAS    = HRESET ? 32'h0 : rdata;
  assign pkt_avail      = ~fifo_empty & ~HRESET;
endmodule
